// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush sequencing for the 5-stage core: load-use, I/D
//               memory waits, taken-branch redirects, halt; perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req_ex_mem,
    input  logic             memread_id_ex,
    input  logic [4:0]       regdest_id_ex,
    input  logic [4:0]       rs_if_id,
    input  logic [4:0]       rt_if_id,
    input  logic             branch_taken_ex_mem,
    input  logic             halt_mem_wb,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_halt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_load_use;
    logic w_resolve;
    logic w_redirect;
    logic w_stall_inc;
    logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
    logic w_if_id_flush, w_id_ex_flush, w_ex_mem_flush;

    // $zero is hardwired, so a load targeting it never creates a dependency
    assign w_load_use = memread_id_ex && (regdest_id_ex != 5'd0) &&
                        ((regdest_id_ex == rs_if_id) || (regdest_id_ex == rt_if_id));

    always_comb begin
        w_state_next   = r_state;
        w_resolve      = 1'b0;
        w_redirect     = 1'b0;
        w_pc_en        = 1'b0;
        w_if_id_en     = 1'b0;
        w_id_ex_en     = 1'b0;
        w_ex_mem_en    = 1'b0;
        w_mem_wb_en    = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;

        if (RST) begin
            w_state_next   = ST_RUN;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (halt_mem_wb)
                        w_state_next = ST_HALT;
                    else if (dmem_req_ex_mem && !dhit)
                        w_state_next = ST_DWAIT;
                    else
                        w_resolve = 1'b1;
                end
                ST_DWAIT: begin
                    if (dhit) begin
                        w_state_next = ST_RUN;
                        w_resolve    = 1'b1;
                    end
                end
                default: w_state_next = ST_HALT;
            endcase

            // Shared by a free-running RUN cycle and the DWAIT release cycle
            if (w_resolve) begin
                w_if_id_en  = 1'b1;
                w_id_ex_en  = 1'b1;
                w_ex_mem_en = 1'b1;
                w_mem_wb_en = 1'b1;
                if (branch_taken_ex_mem) begin
                    w_redirect     = 1'b1;
                    w_pc_en        = 1'b1;
                    w_if_id_flush  = 1'b1;
                    w_id_ex_flush  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                end else if (w_load_use) begin
                    w_if_id_en    = 1'b0;
                    w_id_ex_flush = 1'b1;
                end else if (!ihit) begin
                    w_if_id_flush = 1'b1;
                end else begin
                    w_pc_en = 1'b1;
                end
            end
        end
    end

    assign w_stall_inc = (r_state != ST_HALT) && !w_pc_en;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_RUN;
            r_halt      <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_halt  <= (w_state_next == ST_HALT);
            if (w_stall_inc && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_redirect && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign pc_en        = w_pc_en;
    assign if_id_en     = w_if_id_en;
    assign id_ex_en     = w_id_ex_en;
    assign ex_mem_en    = w_ex_mem_en;
    assign mem_wb_en    = w_mem_wb_en;
    assign if_id_flush  = w_if_id_flush;
    assign id_ex_flush  = w_id_ex_flush;
    assign ex_mem_flush = w_ex_mem_flush;
    assign halt         = r_halt;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Randomized self-checking bench for pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 6;
    localparam int C_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST;
    logic             ihit, dhit, dmem_req_ex_mem, memread_id_ex;
    logic [4:0]       regdest_id_ex, rs_if_id, rt_if_id;
    logic             branch_taken_ex_mem, halt_mem_wb;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, halt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pipeline mode flags and counters
    bit m_halted  = 1'b0;
    bit m_waiting = 1'b0;
    bit m_halt_q  = 1'b0;
    int m_stall   = 0;
    int m_flush   = 0;
    int halt_age  = 0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .ihit                (ihit),
        .dhit                (dhit),
        .dmem_req_ex_mem     (dmem_req_ex_mem),
        .memread_id_ex       (memread_id_ex),
        .regdest_id_ex       (regdest_id_ex),
        .rs_if_id            (rs_if_id),
        .rt_if_id            (rt_if_id),
        .branch_taken_ex_mem (branch_taken_ex_mem),
        .halt_mem_wb         (halt_mem_wb),
        .pc_en               (pc_en),
        .if_id_en            (if_id_en),
        .id_ex_en            (id_ex_en),
        .ex_mem_en           (ex_mem_en),
        .mem_wb_en           (mem_wb_en),
        .if_id_flush         (if_id_flush),
        .id_ex_flush         (id_ex_flush),
        .ex_mem_flush        (ex_mem_flush),
        .halt                (halt),
        .stall_cnt           (stall_cnt),
        .flush_cnt           (flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        logic [7:0] exp_ctl;
        bit         nx_halted, nx_waiting, lu, redirect, stalled;

        RST = 1'b1; ihit = 1'b1; dhit = 1'b1; dmem_req_ex_mem = 1'b0;
        memread_id_ex = 1'b0; regdest_id_ex = '0; rs_if_id = '0; rt_if_id = '0;
        branch_taken_ex_mem = 1'b0; halt_mem_wb = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge CLK);
            RST                 = (cyc < 2) || (halt_age > 4) || ($urandom % 500 == 0);
            ihit                = ($urandom % 4) != 0;
            dhit                = ($urandom % 3) != 0;
            dmem_req_ex_mem     = ($urandom % 3) == 0;
            memread_id_ex       = ($urandom % 3) == 0;
            regdest_id_ex       = 5'($urandom % 4);
            rs_if_id            = 5'($urandom % 4);
            rt_if_id            = 5'($urandom % 4);
            branch_taken_ex_mem = ($urandom % 6) == 0;
            halt_mem_wb         = !m_waiting && (($urandom % 150) == 0);
            #1;

            nx_halted  = m_halted;
            nx_waiting = m_waiting;
            redirect   = 1'b0;
            lu = memread_id_ex && regdest_id_ex != 0 &&
                 (regdest_id_ex == rs_if_id || regdest_id_ex == rt_if_id);
            // bit order: pc, if_id, id_ex, ex_mem, mem_wb enables; if_id, id_ex, ex_mem flushes
            if (RST) begin
                exp_ctl = 8'b00000_111;
                nx_halted = 1'b0; nx_waiting = 1'b0;
            end else if (m_halted) begin
                exp_ctl = 8'b00000_000;
            end else if (!m_waiting && halt_mem_wb) begin
                exp_ctl = 8'b00000_000;
                nx_halted = 1'b1;
            end else if (!dhit && (m_waiting || dmem_req_ex_mem)) begin
                exp_ctl = 8'b00000_000;
                nx_waiting = 1'b1;
            end else begin
                nx_waiting = 1'b0;
                if (branch_taken_ex_mem) begin
                    exp_ctl = 8'b11111_111;
                    redirect = 1'b1;
                end else if (lu)    exp_ctl = 8'b00111_010;
                else if (!ihit)     exp_ctl = 8'b01111_100;
                else                exp_ctl = 8'b11111_000;
            end
            stalled = !RST && !m_halted && !exp_ctl[7];

            check_eq("ctl", {24'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                             if_id_flush, id_ex_flush, ex_mem_flush}, {24'd0, exp_ctl});
            check_eq("halt", {31'd0, halt}, {31'd0, m_halt_q});
            check_eq("stall_cnt", {{(32-CNT_W){1'b0}}, stall_cnt}, 32'(m_stall));
            check_eq("flush_cnt", {{(32-CNT_W){1'b0}}, flush_cnt}, 32'(m_flush));

            @(posedge CLK);
            if (RST) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (stalled && m_stall < C_MAX) m_stall++;
                if (redirect && m_flush < C_MAX) m_flush++;
            end
            m_halted  = nx_halted;
            m_waiting = nx_waiting;
            m_halt_q  = nx_halted;
            halt_age  = m_halted ? halt_age + 1 : 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Generates per-latch enable and flush controls, and the PC enable, for load-use hazards, I/D memory waits, taken-branch redirects and halt.
- The forwarding unit covers ALU-result hazards; this block covers only the hazards forwarding cannot resolve.
- Maintains saturating performance counters.

Parameters:
CNT_W, 16, width of each performance counter

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, synchronous, active-high
ihit  in  1  instruction fetch completes this cycle
dhit  in  1  data access completes this cycle
dmem_req_ex_mem  in  1  EX/MEM instruction is a load or store
memread_id_ex  in  1  ID/EX instruction is a load
regdest_id_ex  in  5  destination register of the ID/EX instruction
rs_if_id  in  5  rs field of the IF/ID instruction
rt_if_id  in  5  rt field of the IF/ID instruction
branch_taken_ex_mem  in  1  branch/jump resolved taken in MEM
halt_mem_wb  in  1  HALT instruction in MEM/WB
pc_en  out  1  PC register load enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  latch advance enables
if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (NOP, all control bits 0) on the next edge
halt  out  1  core halted (registered)
stall_cnt  out  CNT_W  cycles in which pc_en=0 while not halted
flush_cnt  out  CNT_W  taken-branch redirects

Behaviour:
- One clock domain. RST is synchronous and active-high.
- FSM states: RUN, DWAIT, HALT. Reset state is RUN.
- While RST=1: all enables 0, all flushes 1, halt=0, counters 0.
- Outputs are combinational from state and inputs, except halt and the counters, which are registered.
- A flush with enable=1 loads a bubble. A flush overrides its enable.
- RUN priority, highest first:
  1. halt_mem_wb=1: all enables 0, no flush; next state HALT.
  2. dmem_req_ex_mem=1 and dhit=0: all enables 0 (entire pipe frozen); next state DWAIT.
  3. branch_taken_ex_mem=1: pc_en=1 regardless of ihit (the pending fetch is abandoned); all latch enables 1; if_id_flush, id_ex_flush and ex_mem_flush all 1; flush_cnt increments; stay in RUN.
  4. Load-use: memread_id_ex=1, regdest_id_ex!=0, and regdest_id_ex equals rs_if_id or rt_if_id:
     - pc_en=0, if_id_en=0;
     - id_ex_en=1 with id_ex_flush=1;
     - ex_mem_en=1, mem_wb_en=1;
     - stay in RUN. Exactly one bubble is inserted, because the bubble clears memread_id_ex on the next cycle.
  5. ihit=0: pc_en=0, if_id_flush=1, all other enables 1 (the downstream pipe drains).
  6. Otherwise: all enables 1, no flush.
- DWAIT:
  - dhit=0: all enables 0.
  - dhit=1: all enables 1 (MEM/WB captures the load data); next state RUN. Branch and load-use checks apply in this same cycle with RUN priorities 3-5.
  - halt_mem_wb cannot rise while in DWAIT, because MEM/WB is frozen.
- HALT:
  - Absorbing until RST.
  - All enables 0, flushes 0.
  - halt=1 from the first edge after entry.
- Counters:
  - stall_cnt increments each non-RST cycle in state RUN or DWAIT with pc_en=0.
  - flush_cnt increments once per redirect.
  - Both counters saturate at all-ones and do not wrap.
  - Both freeze in HALT.
- Register 0 never triggers a load-use stall.
- A branch in MEM while a dmem wait is pending: the dmem wait wins, and the branch redirects on the dhit cycle.

Test Plan:
1. RST=1 for 2 cycles, then 0, ihit=1, no hazards -> during reset all enables 0 and flushes 1; afterwards all enables 1, flushes 0, stall_cnt=0, halt=0.
2. memread_id_ex=1, regdest_id_ex=8, rs_if_id=8 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt=1. Repeat with regdest_id_ex=0 -> no stall.
3. dmem_req_ex_mem=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles with all enables 0 (state DWAIT); 4th cycle all enables 1; stall_cnt=3; back to RUN.
4. branch_taken_ex_mem=1 with ihit=0 -> pc_en=1, the three flushes =1, flush_cnt=1. The same cycle with dmem_req_ex_mem=1, dhit=0 -> freeze; the redirect occurs on the dhit cycle.
5. halt_mem_wb=1 -> next cycle halt=1; all enables stay 0 thereafter despite ihit and branch inputs; counters frozen; RST=1 returns to RUN with halt=0.
6. Force stall_cnt to 16'hFFFE, then hold ihit=0 for 4 cycles -> stall_cnt reaches 16'hFFFF and holds there.
